// File: rtl/gc_pkg.sv
// Shared constants and FSM state type for the GameCube single-wire protocol.
// Used by both this controller-side responder and the console-side poller.
package gc_pkg;

  localparam logic [7:0] CMD_PROBE = 8'h00;
  localparam logic [7:0] CMD_POLL  = 8'h40;
  localparam logic [7:0] POLL_ARG  = 8'h03;

  // Received lengths include the console stop bit.
  localparam int RX_LEN_PROBE  = 9;
  localparam int RX_LEN_POLL   = 25;
  // Reply lengths exclude the device stop bit.
  localparam int TX_LEN_ID     = 24;
  localparam int TX_LEN_STATUS = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_SAMPLE,
    ST_RX_WAIT,
    ST_EVAL,
    ST_TURN,
    ST_TX_BIT,
    ST_TX_STOP,
    ST_GUARD
  } gc_state_e;

endpackage

// File: rtl/gc_bit_tx.sv
// Single-bit transmitter: pulls the line low for 1T ('1') or 3T ('0') and
// then leaves it released for the rest of the 4T cell; a stop bit is 2T low
// with no trailing high time. done_o is high in the last cycle of the cell so
// the next start can follow on the same edge with no gap.
module gc_bit_tx #(
  parameter int CYCLES_PER_US = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic bit_i,
  input  logic stop_i,
  output logic oe_o,
  output logic done_o
);

  localparam int T  = CYCLES_PER_US;
  localparam int CW = $clog2(3 * T + 1);

  localparam logic [CW-1:0] LAST_1T = CW'(T - 1);
  localparam logic [CW-1:0] LAST_2T = CW'(2 * T - 1);
  localparam logic [CW-1:0] LAST_3T = CW'(3 * T - 1);

  typedef enum logic [1:0] {PH_IDLE, PH_LOW, PH_HIGH} phase_e;

  phase_e          phase_q;
  logic            oe_q;
  logic [CW-1:0]   cnt_q;
  logic            bit_q;
  logic            stop_q;
  logic [CW-1:0]   low_last;
  logic [CW-1:0]   high_last;

  assign low_last  = stop_q ? LAST_2T : (bit_q ? LAST_1T : LAST_3T);
  assign high_last = bit_q ? LAST_3T : LAST_1T;

  assign done_o = ((phase_q == PH_LOW) && stop_q && (cnt_q == low_last)) ||
                  ((phase_q == PH_HIGH) && (cnt_q == high_last));
  assign oe_o   = oe_q;

  // Phase sequencing and the registered open-drain enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_IDLE;
      oe_q    <= 1'b0;
      cnt_q   <= '0;
    end else if (start_i) begin
      phase_q <= PH_LOW;
      oe_q    <= 1'b1;
      cnt_q   <= '0;
    end else begin
      case (phase_q)
        PH_LOW: begin
          if (cnt_q == low_last) begin
            oe_q    <= 1'b0;
            cnt_q   <= '0;
            phase_q <= stop_q ? PH_IDLE : PH_HIGH;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        PH_HIGH: begin
          if (cnt_q == high_last) phase_q <= PH_IDLE;
          else                    cnt_q   <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Bit value and stop flag captured at start; data only, no reset.
  always_ff @(posedge clk) begin
    if (start_i) begin
      bit_q  <= bit_i;
      stop_q <= stop_i;
    end
  end

endmodule

// File: rtl/gc_responder.sv
// Controller-side endpoint of the GameCube/DK Bongos single-wire bus.
// Decodes console probe/poll frames and answers with the ID word or a
// snapshot of the 64-bit status input. The line is only ever pulled low.
module gc_responder
  import gc_pkg::*;
#(
  parameter int          CYCLES_PER_US = 50,
  parameter logic [23:0] ID_WORD       = 24'h090000,
  parameter int          IDLE_US       = 6,
  parameter int          RESP_DELAY_US = 4
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire         dataPort,
  input  logic [63:0] status,
  output logic        poll_strobe,
  output logic        rumble,
  output logic        busy,
  output logic        cmd_err
);

  localparam int T         = CYCLES_PER_US;
  localparam int IDLE_CYC  = IDLE_US * T;
  localparam int DELAY_CYC = RESP_DELAY_US * T;
  localparam int TW        = $clog2(IDLE_CYC + 1);

  localparam logic [TW-1:0] GUARD_LAST  = TW'(T - 1);
  localparam logic [TW-1:0] SAMPLE_LAST = TW'(2 * T - 1);
  localparam logic [TW-1:0] DELAY_LAST  = TW'(DELAY_CYC - 1);
  localparam logic [TW-1:0] IDLE_LAST   = TW'(IDLE_CYC - 1);
  localparam logic [TW-1:0] STUCK_AT    = TW'(IDLE_CYC);

  gc_state_e      state_q;
  logic           sync1_q, sync2_q, prev_q;
  logic [TW-1:0]  tmr_q;
  logic [TW-1:0]  age_q;
  logic [4:0]     rxcnt_q;
  logic [24:0]    sr_q;
  logic [6:0]     idx_q;
  logic [63:0]    snap_q;
  logic           poll_strobe_q, rumble_q, busy_q, cmd_err_q;

  logic           fall, rise, sample_now;
  logic           is_probe, is_poll;
  logic           tx_start, tx_stop, tx_bit, tx_oe, tx_done;
  logic [5:0]     tx_sel;

  assign dataPort = tx_oe ? 1'b0 : 1'bz;

  assign fall       = prev_q & ~sync2_q;
  assign rise       = ~prev_q & sync2_q;
  assign sample_now = (state_q == ST_RX_SAMPLE) && (tmr_q == SAMPLE_LAST);

  // sr_q[0] holds the console stop bit; command bytes sit just above it.
  assign is_probe = (rxcnt_q == 5'(RX_LEN_PROBE)) && (sr_q[8:1] == CMD_PROBE);
  assign is_poll  = (rxcnt_q == 5'(RX_LEN_POLL)) && (sr_q[24:17] == CMD_POLL) &&
                    (sr_q[16:9] == POLL_ARG);

  assign poll_strobe = poll_strobe_q;
  assign rumble      = rumble_q;
  assign busy        = busy_q;
  assign cmd_err     = cmd_err_q;

  // Two-flop synchronizer plus one delayed copy for edge detection; idle high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= dataPort;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Bit start for the transmitter; the next bit is launched in the done cycle.
  always_comb begin
    tx_start = 1'b0;
    tx_stop  = 1'b0;
    tx_sel   = idx_q[5:0];
    case (state_q)
      ST_TURN: tx_start = (tmr_q == DELAY_LAST);
      ST_TX_BIT: begin
        if (tx_done) begin
          tx_start = 1'b1;
          if (idx_q == '0) tx_stop = 1'b1;
          else             tx_sel  = idx_q[5:0] - 6'd1;
        end
      end
      default: ;
    endcase
  end

  assign tx_bit = snap_q[tx_sel];

  // Protocol FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      tmr_q         <= '0;
      age_q         <= '0;
      rxcnt_q       <= '0;
      idx_q         <= '0;
      poll_strobe_q <= 1'b0;
      rumble_q      <= 1'b0;
      busy_q        <= 1'b0;
      cmd_err_q     <= 1'b0;
    end else begin
      poll_strobe_q <= 1'b0;
      cmd_err_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (fall) begin
            state_q <= ST_RX_SAMPLE;
            busy_q  <= 1'b1;
            tmr_q   <= '0;
            age_q   <= '0;
            rxcnt_q <= '0;
          end
        end
        ST_RX_SAMPLE: begin
          // age_q tracks time since the last edge, tmr_q time since the fall.
          age_q <= rise ? '0 : age_q + 1'b1;
          if (tmr_q == SAMPLE_LAST) begin
            rxcnt_q <= (rxcnt_q == 5'd31) ? rxcnt_q : rxcnt_q + 1'b1;
            state_q <= ST_RX_WAIT;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        ST_RX_WAIT: begin
          if (fall) begin
            state_q <= ST_RX_SAMPLE;
            tmr_q   <= '0;
            age_q   <= '0;
          end else if (rise) begin
            age_q <= '0;
          end else if (sync2_q && (age_q == IDLE_LAST)) begin
            state_q <= ST_EVAL;
          end else if (!sync2_q && (age_q == STUCK_AT)) begin
            cmd_err_q <= 1'b1;
            busy_q    <= 1'b0;
            tmr_q     <= '0;
            state_q   <= ST_GUARD;
          end else begin
            age_q <= age_q + 1'b1;
          end
        end
        ST_EVAL: begin
          tmr_q <= '0;
          if (is_probe) begin
            idx_q   <= 7'(TX_LEN_ID - 1);
            state_q <= ST_TURN;
          end else if (is_poll) begin
            idx_q         <= 7'(TX_LEN_STATUS - 1);
            rumble_q      <= sr_q[1];
            poll_strobe_q <= 1'b1;
            state_q       <= ST_TURN;
          end else begin
            cmd_err_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        ST_TURN: begin
          if (tx_start) state_q <= ST_TX_BIT;
          else          tmr_q   <= tmr_q + 1'b1;
        end
        ST_TX_BIT: begin
          if (tx_done) begin
            if (idx_q == '0) state_q <= ST_TX_STOP;
            else             idx_q   <= idx_q - 1'b1;
          end
        end
        ST_TX_STOP: begin
          if (tx_done) begin
            busy_q  <= 1'b0;
            tmr_q   <= '0;
            state_q <= ST_GUARD;
          end
        end
        ST_GUARD: begin
          // Wait for a full 1T of synchronized high so a slow rise is not
          // mistaken for a new falling edge.
          if (!sync2_q)                  tmr_q   <= '0;
          else if (tmr_q == GUARD_LAST)  state_q <= ST_IDLE;
          else                           tmr_q   <= tmr_q + 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Receive shift register and reply snapshot; data only, no reset.
  always_ff @(posedge clk) begin
    if (sample_now) sr_q <= {sr_q[23:0], sync2_q};
    if (state_q == ST_EVAL) snap_q <= is_poll ? status : {40'd0, ID_WORD};
  end

  gc_bit_tx #(
    .CYCLES_PER_US(CYCLES_PER_US)
  ) u_bit_tx (
    .clk    (clk),
    .rst    (rst),
    .start_i(tx_start),
    .bit_i  (tx_bit),
    .stop_i (tx_stop),
    .oe_o   (tx_oe),
    .done_o (tx_done)
  );

endmodule

// File: tb/tb_gc_responder.sv
// Directed bench for gc_responder: the bench plays the console, drives frames
// onto a pulled-up open-drain line and decodes the replies cycle by cycle.
module tb_gc_responder;
  import gc_pkg::*;

  localparam int T = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] status = '0;
  logic        poll_strobe, rumble, busy, cmd_err;
  logic        tb_low = 1'b0;
  wire         dataPort;

  pullup (dataPort);
  assign dataPort = tb_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  gc_responder #(
    .CYCLES_PER_US(T),
    .ID_WORD      (24'h090000),
    .IDLE_US      (6),
    .RESP_DELAY_US(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .dataPort   (dataPort),
    .status     (status),
    .poll_strobe(poll_strobe),
    .rumble     (rumble),
    .busy       (busy),
    .cmd_err    (cmd_err)
  );

  int cyc = 0;
  int n_strobe = 0;
  int n_err = 0;
  int n_dutlow = 0;
  int strobe_cyc = 0;
  int total = 0;
  int bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse and line activity counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (poll_strobe) begin
      n_strobe++;
      strobe_cyc = cyc;
    end
    if (cmd_err) n_err++;
    if (dataPort === 1'b0 && !tb_low) n_dutlow++;
  end

  typedef struct {
    logic [24:0] frame;
    int          nbits;
    logic [63:0] stat;
    int          rlen;
    logic [63:0] rword;
    int          strobes;
    int          errs;
    logic        rum;
    int          chg_at;
    logic [63:0] chg_val;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [24:0] f, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      tb_low = 1'b1;
      step(f[i] ? T : 3 * T);
      tb_low = 1'b0;
      step(f[i] ? 3 * T : T);
    end
  endtask

  task automatic recv_reply(input int nbits, input int chg_at, input logic [63:0] chg_val,
                            input int abort_at, output logic [63:0] word, output int tmis,
                            output int stop_lo, output int first_cyc, output logic busy_seen,
                            output logic tmo);
    int   t;
    int   lo;
    int   hi;
    logic b;
    word = '0; tmis = 0; stop_lo = 0; first_cyc = 0; busy_seen = 1'b0; tmo = 1'b0;
    t = 0;
    while (dataPort !== 1'b0 && t < 1500) begin
      step(1);
      t++;
    end
    if (dataPort !== 1'b0) begin
      tmo = 1'b1;
      return;
    end
    first_cyc = cyc;
    busy_seen = busy;
    for (int i = 0; i < nbits; i++) begin
      if (i == abort_at) return;
      if (i == chg_at) status = chg_val;
      lo = 0;
      while (dataPort === 1'b0 && lo < 400) begin
        lo++;
        step(1);
      end
      hi = 0;
      while (dataPort !== 1'b0 && hi < 400) begin
        hi++;
        step(1);
      end
      b = (lo < 2 * T);
      word = {word[62:0], b};
      if (lo != (b ? T : 3 * T) || hi != (b ? 3 * T : T)) tmis++;
    end
    while (dataPort === 1'b0 && stop_lo < 400) begin
      stop_lo++;
      step(1);
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int          s0, e0, d0, tmis, slo, fc;
    logic [63:0] w;
    logic        bs, tmo;
    step(2 * T);
    status = v.stat;
    s0 = n_strobe; e0 = n_err; d0 = n_dutlow;
    send_frame(v.frame, v.nbits);
    if (v.rlen > 0) begin
      recv_reply(v.rlen, v.chg_at, v.chg_val, -1, w, tmis, slo, fc, bs, tmo);
      chk($sformatf("v%0d.reply_timeout", id), tmo, 1'b0);
      chk($sformatf("v%0d.reply_word", id), w, v.rword);
      chk($sformatf("v%0d.bit_timing_errs", id), tmis, 0);
      chk($sformatf("v%0d.stop_low_len", id), slo, 2 * T);
      chk($sformatf("v%0d.busy_in_reply", id), bs, 1'b1);
      chk($sformatf("v%0d.busy_after_stop", id), busy, 1'b0);
      if (v.strobes > 0) chk($sformatf("v%0d.resp_delay", id), fc - strobe_cyc, 4 * T);
    end else begin
      step(700);
      chk($sformatf("v%0d.no_drive", id), n_dutlow - d0, 0);
      chk($sformatf("v%0d.busy_idle", id), busy, 1'b0);
    end
    chk($sformatf("v%0d.strobe_cycles", id), n_strobe - s0, v.strobes);
    chk($sformatf("v%0d.err_pulses", id), n_err - e0, v.errs);
    chk($sformatf("v%0d.rumble", id), rumble, v.rum);
  endtask

  logic [63:0] pw, s_exp;
  int          ptm, pslo, pfc, s0, e0, d0;
  logic        pbs, ptmo;

  initial begin
    vecs[0] = '{frame: 25'h0000001, nbits: 9, stat: 64'h0, rlen: 24, rword: 64'h090000,
                strobes: 0, errs: 0, rum: 1'b0, chg_at: -1, chg_val: 64'h0};
    vecs[1] = '{frame: 25'h0000083, nbits: 9, stat: 64'h0, rlen: 0, rword: 64'h0,
                strobes: 0, errs: 1, rum: 1'b0, chg_at: -1, chg_val: 64'h0};
    vecs[2] = '{frame: 25'h0000100, nbits: 10, stat: 64'h0, rlen: 0, rword: 64'h0,
                strobes: 0, errs: 1, rum: 1'b0, chg_at: -1, chg_val: 64'h0};
    vecs[3] = '{frame: 25'h0800603, nbits: 25, stat: 64'h0080_0000_8080_8080, rlen: 64,
                rword: 64'h0080_0000_8080_8080, strobes: 1, errs: 0, rum: 1'b1,
                chg_at: 8, chg_val: 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[4] = '{frame: 25'h0800601, nbits: 25, stat: 64'h0123_4567_89AB_CDEF, rlen: 64,
                rword: 64'h0123_4567_89AB_CDEF, strobes: 1, errs: 0, rum: 1'b0,
                chg_at: -1, chg_val: 64'h0};

    step(5);
    chk("reset.line", dataPort, 1'b1);
    chk("reset.busy", busy, 1'b0);
    chk("reset.strobe", poll_strobe, 1'b0);
    chk("reset.rumble", rumble, 1'b0);
    chk("reset.cmd_err", cmd_err, 1'b0);
    rst = 1'b0;
    step(5);

    for (int k = 0; k < 5; k++) run_vec(vecs[k], k);

    // Reset asserted while the reply is at bit 30.
    step(2 * T);
    status = 64'h0080_0000_8080_8080;
    s0 = n_strobe;
    send_frame(25'h0800603, 25);
    recv_reply(64, -1, 64'h0, 30, pw, ptm, pslo, pfc, pbs, ptmo);
    chk("rstmid.timeout", ptmo, 1'b0);
    s_exp = status >> 34;
    chk("rstmid.partial_word", pw, s_exp);
    chk("rstmid.rumble_before", rumble, 1'b1);
    chk("rstmid.strobe_cycles", n_strobe - s0, 1);
    rst = 1'b1;
    step(1);
    chk("rstmid.line", dataPort, 1'b1);
    chk("rstmid.busy", busy, 1'b0);
    chk("rstmid.rumble", rumble, 1'b0);
    rst = 1'b0;
    d0 = n_dutlow;
    step(20);
    chk("rstmid.released", n_dutlow - d0, 0);
    run_vec(vecs[0], 10);

    // Line stuck low for 400 cycles.
    step(2 * T);
    e0 = n_err; d0 = n_dutlow; s0 = n_strobe;
    tb_low = 1'b1;
    step(400);
    tb_low = 1'b0;
    step(T + 20);
    chk("stuck.err_pulses", n_err - e0, 1);
    chk("stuck.no_drive", n_dutlow - d0, 0);
    chk("stuck.no_strobe", n_strobe - s0, 0);
    chk("stuck.busy", busy, 1'b0);
    run_vec(vecs[0], 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
